// File: rtl/fetch.sv
// Instruction fetch stage of the nebula core: owns the PC, issues word requests to
// instruction memory and presents buffered pc/instruction pairs to decode.
module fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    output logic        imem_req_valid_o,
    input  logic        imem_req_ready_i,
    output logic [31:0] imem_addr_o,
    input  logic        imem_resp_valid_i,
    input  logic [31:0] imem_resp_data_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [31:0] pc_o,
    output logic [31:0] instr_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [31:0]   pc_q;
    logic [31:0]   pc_buf    [DEPTH];
    logic [31:0]   instr_buf [DEPTH];
    logic [31:0]   tag_buf   [DEPTH];
    logic [AW-1:0] rd_ptr_q;
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] tag_rd_q;
    logic [AW-1:0] tag_wr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] inflight_q;
    logic [CW-1:0] discard_q;
    logic [CW+1:0] used;
    logic          accept;
    logic          resp_counted;
    logic          resp_drop;
    logic          resp_keep;
    logic          pop;

    // Every buffered, in-flight or to-be-discarded word holds a credit, so the
    // buffer always has room for whatever the memory returns.
    assign used = (CW+2)'(count_q) + (CW+2)'(inflight_q) + (CW+2)'(discard_q);

    assign imem_req_valid_o = rst_n_i && !redirect_i && (used < (CW+2)'(DEPTH));
    assign imem_addr_o      = pc_q;
    assign accept           = imem_req_valid_o && imem_req_ready_i;

    assign resp_counted = imem_resp_valid_i && ((discard_q != '0) || (inflight_q != '0));
    assign resp_drop    = imem_resp_valid_i && (discard_q != '0);
    assign resp_keep    = imem_resp_valid_i && (discard_q == '0) && (inflight_q != '0) && !redirect_i;

    assign valid_o = (count_q != '0);
    assign pop     = valid_o && ready_i;
    assign pc_o    = valid_o ? pc_buf[rd_ptr_q]    : 32'h0;
    assign instr_o = valid_o ? instr_buf[rd_ptr_q] : 32'h0;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pc_q       <= RESET_PC & ~32'h3;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            tag_rd_q   <= '0;
            tag_wr_q   <= '0;
            count_q    <= '0;
            inflight_q <= '0;
            discard_q  <= '0;
        end else if (redirect_i) begin
            // Outstanding fetches turn into discards; a response arriving now retires one of them.
            pc_q       <= redirect_pc_i & ~32'h3;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            tag_rd_q   <= '0;
            tag_wr_q   <= '0;
            count_q    <= '0;
            inflight_q <= '0;
            discard_q  <= discard_q + inflight_q - CW'(resp_counted);
        end else begin
            if (accept) begin
                pc_q     <= pc_q + 32'd4;
                tag_wr_q <= tag_wr_q + AW'(1);
            end
            if (resp_keep) begin
                tag_rd_q <= tag_rd_q + AW'(1);
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (resp_drop) begin
                discard_q <= discard_q - CW'(1);
            end
            count_q    <= count_q + CW'(resp_keep) - CW'(pop);
            inflight_q <= inflight_q + CW'(accept) - CW'(resp_keep);
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept) begin
            tag_buf[tag_wr_q] <= pc_q;
        end
        if (resp_keep) begin
            pc_buf[wr_ptr_q]    <= tag_buf[tag_rd_q];
            instr_buf[wr_ptr_q] <= imem_resp_data_i;
        end
    end

    resp_without_request: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        imem_resp_valid_i |-> ((inflight_q != '0) || (discard_q != '0)));

endmodule

// File: tb/tb_fetch.sv
// Directed bench for the fetch stage: an in-order memory model with programmable
// latency plus a decode-side scoreboard of the expected pc sequence.
module tb_fetch;

    logic        clk;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        valid;
    logic        ready;
    logic [31:0] pc;
    logic [31:0] instr;

    int          errors   = 0;
    int          checks   = 0;
    int          consumed = 0;
    int          cyc      = 0;
    int          lat      = 1;
    int          mark;
    logic [31:0] exp_pc;

    typedef struct packed {
        logic [31:0] addr;
        int          due;
    } pend_t;
    pend_t pend[$];

    fetch #(.RESET_PC(32'h0000_1000), .DEPTH(4)) dut (
        .clk_i            (clk),
        .rst_n_i          (rst_n),
        .imem_req_valid_o (imem_req_valid),
        .imem_req_ready_i (imem_req_ready),
        .imem_addr_o      (imem_addr),
        .imem_resp_valid_i(imem_resp_valid),
        .imem_resp_data_i (imem_resp_data),
        .redirect_i       (redirect),
        .redirect_pc_i    (redirect_pc),
        .valid_o          (valid),
        .ready_i          (ready),
        .pc_o             (pc),
        .instr_o          (instr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] memWord(input logic [31:0] addr);
        return addr ^ 32'hDEAD_BEEF;
    endfunction

    // Memory model: accept sampled mid-cycle, responses returned in order after lat cycles.
    initial begin
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        forever begin
            @(negedge clk);
            if (rst_n && imem_req_valid && imem_req_ready)
                pend.push_back('{addr: imem_addr, due: cyc + lat});
            @(posedge clk);
            #1;
            if (!rst_n) begin
                pend.delete();
                imem_resp_valid = 1'b0;
            end else if (pend.size() > 0 && pend[0].due <= cyc) begin
                imem_resp_valid = 1'b1;
                imem_resp_data  = memWord(pend[0].addr);
                void'(pend.pop_front());
            end else begin
                imem_resp_valid = 1'b0;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        assert (got === expv) else begin
            errors++;
            $error("[TB] FAIL %s: got %h expected %h", tag, got, expv);
        end
    endtask

    // Called after the mid-cycle sample point; scores any decode handshake, then
    // advances to just after the next rising edge where inputs are changed.
    task automatic finishCycle();
        if (valid && ready) begin
            checkOutput("stream_pc", pc, exp_pc);
            checkOutput("stream_instr", instr, memWord(exp_pc));
            exp_pc = exp_pc + 32'd4;
            consumed++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            finishCycle();
        end
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        applyStimulus(2);
        rst_n  = 1'b1;
        exp_pc = 32'h0000_1000;
    endtask

    initial begin
        rst_n          = 1'b0;
        ready          = 1'b1;
        imem_req_ready = 1'b1;
        redirect       = 1'b0;
        redirect_pc    = 32'h0;
        exp_pc         = 32'h0000_1000;

        // Reset values
        @(negedge clk);
        checkOutput("rst_valid", 32'(valid), 32'd0);
        checkOutput("rst_req_valid", 32'(imem_req_valid), 32'd0);
        checkOutput("rst_addr", imem_addr, 32'h0000_1000);
        checkOutput("rst_pc", pc, 32'h0);
        checkOutput("rst_instr", instr, 32'h0);
        finishCycle();
        applyStimulus(1);
        rst_n = 1'b1;

        // Startup with 1-cycle memory: first valid two cycles after first accept
        @(negedge clk);
        checkOutput("c0_req_valid", 32'(imem_req_valid), 32'd1);
        checkOutput("c0_addr", imem_addr, 32'h0000_1000);
        checkOutput("c0_valid", 32'(valid), 32'd0);
        finishCycle();
        @(negedge clk);
        checkOutput("c1_valid", 32'(valid), 32'd0);
        checkOutput("c1_addr", imem_addr, 32'h0000_1004);
        finishCycle();
        @(negedge clk);
        checkOutput("c2_valid", 32'(valid), 32'd1);
        checkOutput("c2_pc", pc, 32'h0000_1000);
        finishCycle();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checkOutput("thru_valid", 32'(valid), 32'd1);
            finishCycle();
        end

        // Decode stall: buffer fills, requests stop, head holds
        ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("stall_req_valid", 32'(imem_req_valid), (i < 2) ? 32'd1 : 32'd0);
            checkOutput("stall_valid", 32'(valid), 32'd1);
            checkOutput("stall_pc", pc, exp_pc);
            checkOutput("stall_instr", instr, memWord(exp_pc));
            finishCycle();
        end
        ready = 1'b1;
        mark  = consumed;
        applyStimulus(12);
        checkOutput("drain_count", 32'(consumed - mark), 32'd12);

        // Redirect with two fetches in flight, latency 3
        lat = 3;
        doReset();
        applyStimulus(2);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_2002;
        @(negedge clk);
        checkOutput("rd3_req_blocked", 32'(imem_req_valid), 32'd0);
        finishCycle();
        redirect = 1'b0;
        exp_pc   = 32'h0000_2000;
        @(negedge clk);
        checkOutput("rd3_c3_valid", 32'(valid), 32'd0);
        checkOutput("rd3_c3_addr", imem_addr, 32'h0000_2000);
        checkOutput("rd3_c3_req_valid", 32'(imem_req_valid), 32'd1);
        finishCycle();
        @(negedge clk);
        checkOutput("rd3_c4_valid", 32'(valid), 32'd0);
        finishCycle();
        @(negedge clk);
        checkOutput("rd3_c5_valid", 32'(valid), 32'd0);
        checkOutput("rd3_c5_addr", imem_addr, 32'h0000_2008);
        finishCycle();
        @(negedge clk);
        checkOutput("rd3_c6_valid", 32'(valid), 32'd0);
        finishCycle();
        @(negedge clk);
        checkOutput("rd3_c7_valid", 32'(valid), 32'd1);
        checkOutput("rd3_c7_pc", pc, 32'h0000_2000);
        finishCycle();
        applyStimulus(6);

        // Redirect coinciding with a response and a decode handshake, latency 2
        lat = 2;
        doReset();
        applyStimulus(4);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_3000;
        @(negedge clk);
        checkOutput("rd2_handshake_valid", 32'(valid), 32'd1);
        checkOutput("rd2_resp_valid", 32'(imem_resp_valid), 32'd1);
        checkOutput("rd2_req_blocked", 32'(imem_req_valid), 32'd0);
        finishCycle();
        redirect = 1'b0;
        exp_pc   = 32'h0000_3000;
        @(negedge clk);
        checkOutput("rd2_c5_valid", 32'(valid), 32'd0);
        checkOutput("rd2_c5_req_valid", 32'(imem_req_valid), 32'd1);
        checkOutput("rd2_c5_addr", imem_addr, 32'h0000_3000);
        finishCycle();
        @(negedge clk);
        checkOutput("rd2_c6_valid", 32'(valid), 32'd0);
        finishCycle();
        @(negedge clk);
        checkOutput("rd2_c7_valid", 32'(valid), 32'd0);
        finishCycle();
        @(negedge clk);
        checkOutput("rd2_c8_valid", 32'(valid), 32'd1);
        checkOutput("rd2_c8_pc", pc, 32'h0000_3000);
        finishCycle();
        applyStimulus(4);

        // Wrap-around at the top of the address space with a jittery memory
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        @(negedge clk);
        finishCycle();
        redirect = 1'b0;
        exp_pc   = 32'hFFFF_FFFC;
        mark     = consumed;
        for (int i = 0; i < 40; i++) begin
            imem_req_ready = (i % 3 == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            @(negedge clk);
            finishCycle();
        end
        imem_req_ready = 1'b1;
        checkOutput("wrap_progress", 32'(consumed - mark >= 4), 32'd1);

        // Asynchronous reset with a non-empty buffer and two fetches in flight
        lat   = 3;
        ready = 1'b0;
        doReset();
        applyStimulus(5);
        @(negedge clk);
        checkOutput("prereset_valid", 32'(valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_valid", 32'(valid), 32'd0);
        checkOutput("async_req_valid", 32'(imem_req_valid), 32'd0);
        checkOutput("async_pc", pc, 32'h0);
        checkOutput("async_addr", imem_addr, 32'h0000_1000);
        @(posedge clk);
        #1;
        applyStimulus(1);
        rst_n  = 1'b1;
        ready  = 1'b1;
        lat    = 1;
        exp_pc = 32'h0000_1000;
        @(negedge clk);
        checkOutput("post_req_valid", 32'(imem_req_valid), 32'd1);
        checkOutput("post_addr", imem_addr, 32'h0000_1000);
        finishCycle();
        applyStimulus(1);
        @(negedge clk);
        checkOutput("post_valid", 32'(valid), 32'd1);
        checkOutput("post_pc", pc, 32'h0000_1000);
        finishCycle();
        applyStimulus(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
